// File: rtl/flicker_pkg.sv
// Shared types and default sizing for the flicker link endpoint.
package flicker_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned RX_DEPTH   = 4;

    typedef enum logic {
        TX_IDLE     = 1'b0,
        TX_WAIT_ACK = 1'b1
    } tx_state_t;

endpackage

// File: rtl/flicker_rx_fifo.sv
// Small synchronous FIFO for the inbound lane; push is refused while full,
// pop is ignored while empty, occupancy kept in a separate counter.
module flicker_rx_fifo #(
    parameter int unsigned pWIDTH = 8,
    parameter int unsigned pDEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_i,
    input  logic                       push_i,
    input  logic [pWIDTH-1:0]          data_i,
    input  logic                       pop_i,
    output logic [pWIDTH-1:0]          data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(pDEPTH):0]    level_o
);

    localparam int unsigned AW = $clog2(pDEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   LVL_ONE  = 1;
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(pDEPTH);

    logic [pWIDTH-1:0] mem_q [pDEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       level_q, level_d;
    logic              do_push, do_pop;

    assign full_o  = (level_q == LVL_FULL);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/flicker_link_endpoint.sv
// Toggle-flag link endpoint: reader on the inbound lane, writer on the outbound lane.
// Define FLICKER_SYNC_EN to pass in_flicker_i/out_ack_i through 2-flop synchronizers.
module flicker_link_endpoint
    import flicker_pkg::*;
#(
    parameter int unsigned pDATA_WIDTH = DATA_WIDTH,
    parameter int unsigned pRX_DEPTH   = RX_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset_i,
    input  logic [pDATA_WIDTH-1:0]       in_data_i,
    input  logic                         in_flicker_i,
    output logic                         in_ack_o,
    output logic [pDATA_WIDTH-1:0]       out_data_o,
    output logic                         out_flicker_o,
    input  logic                         out_ack_i,
    output logic [pDATA_WIDTH-1:0]       rx_data_o,
    output logic                         rx_valid_o,
    input  logic                         rx_ready_i,
    input  logic [pDATA_WIDTH-1:0]       tx_data_i,
    input  logic                         tx_valid_i,
    output logic                         tx_ready_o,
    output logic [$clog2(pRX_DEPTH):0]   rx_level_o
);

    logic in_flicker_s;
    logic out_ack_s;

`ifdef FLICKER_SYNC_EN
    logic [1:0] in_sync_q, in_sync_d;
    logic [1:0] out_sync_q, out_sync_d;

    always_comb begin
        in_sync_d  = {in_sync_q[0], in_flicker_i};
        out_sync_d = {out_sync_q[0], out_ack_i};
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            in_sync_q  <= '0;
            out_sync_q <= '0;
        end else begin
            in_sync_q  <= in_sync_d;
            out_sync_q <= out_sync_d;
        end
    end

    assign in_flicker_s = in_sync_q[1];
    assign out_ack_s    = out_sync_q[1];
`else
    assign in_flicker_s = in_flicker_i;
    assign out_ack_s    = out_ack_i;
`endif

    logic in_ack_q, in_ack_d;
    logic rx_push, rx_full, rx_empty;

    // Ack is withheld while full, which stalls the peer instead of dropping.
    always_comb begin
        rx_push  = (in_flicker_s != in_ack_q) && !rx_full;
        in_ack_d = in_ack_q ^ rx_push;
    end

    flicker_rx_fifo #(
        .pWIDTH (pDATA_WIDTH),
        .pDEPTH (pRX_DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .reset_i (reset_i),
        .push_i  (rx_push),
        .data_i  (in_data_i),
        .pop_i   (rx_ready_i),
        .data_o  (rx_data_o),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .level_o (rx_level_o)
    );

    assign rx_valid_o = !rx_empty;
    assign in_ack_o   = in_ack_q;

    tx_state_t              state_q, state_d;
    logic [pDATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                   out_flicker_q, out_flicker_d;

    always_comb begin
        state_d       = state_q;
        out_data_d    = out_data_q;
        out_flicker_d = out_flicker_q;
        tx_ready_o    = 1'b0;
        unique case (state_q)
            TX_IDLE: begin
                tx_ready_o = 1'b1;
                if (tx_valid_i) begin
                    out_data_d    = tx_data_i;
                    out_flicker_d = !out_flicker_q;
                    state_d       = TX_WAIT_ACK;
                end
            end
            TX_WAIT_ACK: begin
                if (out_ack_s == out_flicker_q) begin
                    state_d = TX_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= TX_IDLE;
            out_data_q    <= '0;
            out_flicker_q <= 1'b0;
            in_ack_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            out_data_q    <= out_data_d;
            out_flicker_q <= out_flicker_d;
            in_ack_q      <= in_ack_d;
        end
    end

    assign out_data_o    = out_data_q;
    assign out_flicker_o = out_flicker_q;

endmodule

// File: tb/tb_flicker_link_endpoint.sv
// Scoreboard bench for flicker_link_endpoint: directed lane checks plus
// randomized concurrent traffic against queue-based peer models.
module tb_flicker_link_endpoint;

`ifdef FLICKER_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int LW = $clog2(D) + 1;
    localparam int NBYTES = 40;

    logic          clk = 1'b0;
    logic          reset_i;
    logic [W-1:0]  in_data_i;
    logic          in_flicker_i;
    logic          in_ack_o;
    logic [W-1:0]  out_data_o;
    logic          out_flicker_o;
    logic          out_ack_i;
    logic [W-1:0]  rx_data_o;
    logic          rx_valid_o;
    logic          rx_ready_i;
    logic [W-1:0]  tx_data_i;
    logic          tx_valid_i;
    logic          tx_ready_o;
    logic [LW-1:0] rx_level_o;

    flicker_link_endpoint #(
        .pDATA_WIDTH (W),
        .pRX_DEPTH   (D)
    ) dut (
        .clk           (clk),
        .reset_i       (reset_i),
        .in_data_i     (in_data_i),
        .in_flicker_i  (in_flicker_i),
        .in_ack_o      (in_ack_o),
        .out_data_o    (out_data_o),
        .out_flicker_o (out_flicker_o),
        .out_ack_i     (out_ack_i),
        .rx_data_o     (rx_data_o),
        .rx_valid_o    (rx_valid_o),
        .rx_ready_i    (rx_ready_i),
        .tx_data_i     (tx_data_i),
        .tx_valid_i    (tx_valid_i),
        .tx_ready_o    (tx_ready_o),
        .rx_level_o    (rx_level_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] rx_exp[$];
    logic [W-1:0] tx_exp[$];
    logic in_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Peer writer: present a byte, toggle, wait for our ack. lat counts negedges.
    task automatic send_in(input logic [W-1:0] d, output int lat);
        tick();
        in_data_i    = d;
        in_flicker_i = !in_flicker_i;
        rx_exp.push_back(d);
        lat = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (in_ack_o == in_flicker_i) break;
        end
        if (in_ack_o != in_flicker_i)
            check("in_ack_timeout", in_ack_o, in_flicker_i);
    endtask

    // Consumer-side monitor: a pop happens on the next edge.
    always @(negedge clk) begin
        if (!reset_i && rx_valid_o && rx_ready_i) begin
            if (rx_exp.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rx_unexpected: got %0h expected none", rx_data_o);
            end else begin
                check("rx_data", rx_data_o, rx_exp.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        reset_i      = 1'b1;
        in_data_i    = '0;
        in_flicker_i = 1'b0;
        out_ack_i    = 1'b0;
        rx_ready_i   = 1'b0;
        tx_data_i    = '0;
        tx_valid_i   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ack", in_ack_o, 0);
        check("rst_out_flicker", out_flicker_o, 0);
        check("rst_out_data", out_data_o, 0);
        check("rst_rx_valid", rx_valid_o, 0);
        check("rst_rx_level", rx_level_o, 0);
        check("rst_rx_data", rx_data_o, 0);
        check("rst_tx_ready", tx_ready_o, 1);
        tick();
        reset_i = 1'b0;

        // Single inbound byte
        send_in(8'hA5, lat);
        check("in_latency", lat, 2 + SYNC_LAT);
        check("in_ack_toggled", in_ack_o, 1);
        check("in_rx_valid", rx_valid_o, 1);
        check("in_rx_data", rx_data_o, 8'hA5);
        check("in_rx_level", rx_level_o, 1);
        tick();
        rx_ready_i = 1'b1;
        tick();
        rx_ready_i = 1'b0;
        @(negedge clk);
        check("in_rx_empty", rx_valid_o, 0);

        // FIFO full backpressure
        for (int i = 1; i <= 4; i++) send_in(W'(i), lat);
        check("full_level", rx_level_o, 4);
        tick();
        in_data_i    = 8'h05;
        in_flicker_i = !in_flicker_i;
        rx_exp.push_back(8'h05);
        repeat (6) @(negedge clk);
        check("full_ack_withheld", in_ack_o, !in_flicker_i);
        check("full_level_hold", rx_level_o, 4);
        tick();
        rx_ready_i = 1'b1;
        tick();
        rx_ready_i = 1'b0;
        @(negedge clk);
        check("full_no_same_cycle_push", in_ack_o, !in_flicker_i);
        check("full_level_after_pop", rx_level_o, 3);
        @(negedge clk);
        check("full_late_ack", in_ack_o, in_flicker_i);
        check("full_level_refill", rx_level_o, 4);
        tick();
        rx_ready_i = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!rx_valid_o) break;
        end
        check("drain_empty", rx_valid_o, 0);
        check("drain_queue", rx_exp.size(), 0);
        tick();
        rx_ready_i = 1'b0;

        // Single outbound byte with a slow ack
        tick();
        tx_data_i  = 8'h3C;
        tx_valid_i = 1'b1;
        @(negedge clk);
        check("tx_ready_idle", tx_ready_o, 1);
        tick();
        tx_valid_i = 1'b0;
        @(negedge clk);
        check("tx_out_data", out_data_o, 8'h3C);
        check("tx_out_flicker", out_flicker_o, 1);
        check("tx_ready_busy", tx_ready_o, 0);
        repeat (10) @(negedge clk);
        check("tx_ready_wait", tx_ready_o, 0);
        check("tx_data_hold", out_data_o, 8'h3C);
        tick();
        out_ack_i = 1'b1;
        lat = 0;
        while (lat < 50) begin
            @(negedge clk);
            lat++;
            if (tx_ready_o) break;
        end
        check("tx_ack_latency", lat, 2 + SYNC_LAT);
        check("tx_flicker_stable", out_flicker_o, 1);

        // Reset in the middle of an outbound transfer with 2 bytes queued
        tick();
        tx_data_i  = 8'h77;
        tx_valid_i = 1'b1;
        tick();
        tx_valid_i = 1'b0;
        send_in(8'h11, lat);
        send_in(8'h22, lat);
        check("mid_level", rx_level_o, 2);
        check("mid_tx_busy", tx_ready_o, 0);
        @(posedge clk);
        #3;
        reset_i = 1'b1;
        #1;
        check("arst_in_ack", in_ack_o, 0);
        check("arst_out_flicker", out_flicker_o, 0);
        check("arst_out_data", out_data_o, 0);
        check("arst_rx_valid", rx_valid_o, 0);
        check("arst_rx_level", rx_level_o, 0);
        check("arst_rx_data", rx_data_o, 0);
        check("arst_tx_ready", tx_ready_o, 1);
        in_flicker_i = 1'b0;
        out_ack_i    = 1'b0;
        rx_exp.delete();
        tx_exp.delete();
        repeat (2) @(negedge clk);
        tick();
        reset_i = 1'b0;

        // Concurrent randomized traffic on both lanes
        fork
            begin
                int l;
                for (int n = 0; n < NBYTES; n++) begin
                    repeat ($urandom_range(0, 7)) tick();
                    send_in(W'($urandom), l);
                end
                in_done = 1'b1;
            end
            begin
                for (int c = 0; c < 5000; c++) begin
                    tick();
                    rx_ready_i = in_done || ($urandom_range(0, 1) == 1);
                    if (in_done && rx_exp.size() == 0) break;
                end
            end
            begin
                for (int n = 0; n < NBYTES; n++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    tick();
                    tx_data_i  = W'($urandom);
                    tx_valid_i = 1'b1;
                    for (int c = 0; c < 200; c++) begin
                        @(negedge clk);
                        if (tx_ready_o) break;
                    end
                    if (!tx_ready_o) check("tx_accept_timeout", tx_ready_o, 1);
                    tx_exp.push_back(tx_data_i);
                    tick();
                    tx_valid_i = 1'b0;
                end
            end
            begin
                logic want;
                for (int n = 0; n < NBYTES; n++) begin
                    for (int c = 0; c < 300; c++) begin
                        @(negedge clk);
                        if (out_flicker_o != out_ack_i) break;
                    end
                    if (out_flicker_o == out_ack_i) begin
                        want = !out_ack_i;
                        check("out_flicker_timeout", out_flicker_o, want);
                    end else if (tx_exp.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL out_unexpected: got %0h expected none", out_data_o);
                    end else begin
                        check("out_data", out_data_o, tx_exp.pop_front());
                    end
                    repeat ($urandom_range(0, 7)) tick();
                    tick();
                    out_ack_i = out_flicker_o;
                end
            end
        join

        repeat (3 + SYNC_LAT) @(negedge clk);
        check("final_rx_queue", rx_exp.size(), 0);
        check("final_tx_queue", tx_exp.size(), 0);
        check("final_rx_level", rx_level_o, 0);
        check("final_in_ack", in_ack_o, in_flicker_i);
        check("final_tx_ready", tx_ready_o, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
